// File: rtl/button_event_reader_pkg.sv
// Shared constants, event kind encoding and sizing helper for the button event reader.
// Board timing defaults: a 12 MHz clock and a 10 ms debounce window.
package button_event_reader_pkg;

  localparam int CLK_HZ                = 12_000_000;
  localparam int DEBOUNCE_MS           = 10;
  localparam bit BTN_ACTIVE_LOW        = 1'b1;
  localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic {
    EVT_RELEASE = 1'b0,
    EVT_PRESS   = 1'b1
  } evt_kind_e;

  // The event id is never narrower than one bit, even for a single button.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_event_reader_if.sv
// Valid/ready event stream carrying a button index and a press/release flag.
// The producer drives the master modport, the consumer the slave modport.
interface button_event_reader_if #(
  parameter int ID_W = 2
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_press;

  modport master (output evt_valid, output evt_id, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_press, output evt_ready);

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: polarity fix, 2-flop synchroniser, stability counter and
// debounced level, plus combinational rise/fall pulses on the edge the level changes.
module btn_debounce_ch #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clki,
  input  logic reset,
  input  logic i_raw,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);

  logic             w_pressed;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  // Polarity is normalised before the synchroniser so reset can load "released" as 0.
  assign w_pressed = i_raw ^ ACTIVE_LOW;
  assign w_diff    = (r_sync2 != r_state);
  assign w_done    = w_diff && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  always_ff @(posedge clki) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_pressed;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_state <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_state = r_state;
  assign o_rise  = w_done &  r_sync2;
  assign o_fall  = w_done & ~r_sync2;

endmodule

// File: rtl/button_event_reader.sv
// Debounces N_BTN buttons and emits one press/release event per debounced edge
// over a valid/ready stream, with per-channel pending bits and a sticky overflow flag.
module button_event_reader
  import button_event_reader_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = BTN_ACTIVE_LOW
) (
  input  logic                  clki,
  input  logic                  reset,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_state,
  output logic                  overflow,
  button_event_reader_if.master evt
);

  localparam int ID_W = id_width(N_BTN);

  logic [N_BTN-1:0] w_state;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_fall;
  logic [N_BTN-1:0] r_pend_press;
  logic [N_BTN-1:0] r_pend_rel;
  logic [N_BTN-1:0] w_cons_press;
  logic [N_BTN-1:0] w_cons_rel;
  logic [N_BTN-1:0] w_pend_press_next;
  logic [N_BTN-1:0] w_pend_rel_next;
  logic             w_lost;

  logic             w_found;
  logic [ID_W-1:0]  w_sel_id;
  evt_kind_e        w_sel_kind;
  logic             w_load;

  logic             r_evt_valid;
  logic [ID_W-1:0]  r_evt_id;
  evt_kind_e        r_evt_kind;
  logic             r_overflow;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_ch (
        .clki    (clki),
        .reset   (reset),
        .i_raw   (btn_raw[gi]),
        .o_state (w_state[gi]),
        .o_rise  (w_rise[gi]),
        .o_fall  (w_fall[gi])
      );

      assign w_cons_press[gi] = w_load && w_found && (w_sel_id == ID_W'(gi)) &&
                                (w_sel_kind == EVT_PRESS);
      assign w_cons_rel[gi]   = w_load && w_found && (w_sel_id == ID_W'(gi)) &&
                                (w_sel_kind == EVT_RELEASE);
    end
  endgenerate

  // Lowest index wins; within a channel a pending press is served before a release.
  always_comb begin
    w_found    = 1'b0;
    w_sel_id   = '0;
    w_sel_kind = EVT_RELEASE;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend_press[i] || r_pend_rel[i]) begin
        w_found    = 1'b1;
        w_sel_id   = ID_W'(i);
        w_sel_kind = r_pend_press[i] ? EVT_PRESS : EVT_RELEASE;
      end
    end
  end

  assign w_load = !r_evt_valid || evt.evt_ready;

  // A bit consumed and re-set on the same edge is a fresh event, not a lost one.
  assign w_pend_press_next = (r_pend_press & ~w_cons_press) | w_rise;
  assign w_pend_rel_next   = (r_pend_rel   & ~w_cons_rel)   | w_fall;
  assign w_lost = |((w_rise & r_pend_press & ~w_cons_press) |
                    (w_fall & r_pend_rel   & ~w_cons_rel));

  always_ff @(posedge clki) begin
    if (reset) begin
      r_pend_press <= '0;
      r_pend_rel   <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_evt_kind   <= EVT_RELEASE;
      r_overflow   <= 1'b0;
    end else begin
      r_pend_press <= w_pend_press_next;
      r_pend_rel   <= w_pend_rel_next;
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_evt_valid <= w_found;
        if (w_found) begin
          r_evt_id   <= w_sel_id;
          r_evt_kind <= w_sel_kind;
        end
      end
    end
  end

  assign btn_state     = w_state;
  assign overflow      = r_overflow;
  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_id    = r_evt_id;
  assign evt.evt_press = r_evt_kind;

endmodule

// File: tb/tb_button_event_reader.sv
// Directed scenarios plus randomized button/ready traffic, checked every cycle
// against a behavioural model built from sample histories and pending-event flags.
module tb_button_event_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] state;
  logic         ovf;

  button_event_reader_if #(.ID_W(2)) evt_bus ();

  button_event_reader #(
    .N_BTN         (N),
    .STABLE_CYCLES (S),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clki      (clk),
    .reset     (rst),
    .btn_raw   (raw),
    .btn_state (state),
    .overflow  (ovf),
    .evt       (evt_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel keeps the last S synchronised samples; the debounced level flips
  // when all of them disagree with it. Events are per-channel press/release flags.
  bit m_s1[N], m_s2[N], m_state[N];
  bit m_hist[N][S];
  bit m_pp[N], m_pr[N];
  bit m_rise[N], m_fall[N];
  bit m_valid, m_press, m_ovf;
  int m_id;
  bit m_all, m_cmp, m_found, m_load;
  int m_fch;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_state[c] = 0; m_pp[c] = 0; m_pr[c] = 0;
        for (int j = 0; j < S; j++) m_hist[c][j] = 0;
      end
      m_valid = 0; m_press = 0; m_id = 0; m_ovf = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        m_cmp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = ~raw[c];
        for (int j = S - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
        m_hist[c][0] = m_cmp;
        m_all = 1;
        for (int j = 0; j < S; j++) if (m_hist[c][j] == m_state[c]) m_all = 0;
        m_rise[c] = m_all && !m_state[c];
        m_fall[c] = m_all &&  m_state[c];
        if (m_all) m_state[c] = ~m_state[c];
      end
      m_load = !m_valid || evt_bus.evt_ready;
      if (m_load) begin
        m_found = 0; m_fch = 0;
        for (int c = N - 1; c >= 0; c--) if (m_pp[c] || m_pr[c]) begin m_found = 1; m_fch = c; end
        if (m_found) begin
          m_valid = 1; m_id = m_fch; m_press = m_pp[m_fch];
          if (m_pp[m_fch]) m_pp[m_fch] = 0; else m_pr[m_fch] = 0;
        end else begin
          m_valid = 0;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (m_rise[c]) begin if (m_pp[c]) m_ovf = 1; m_pp[c] = 1; end
        if (m_fall[c]) begin if (m_pr[c]) m_ovf = 1; m_pr[c] = 1; end
      end
    end
  end

  int m_state_packed;
  always @(negedge clk) begin
    m_state_packed = 0;
    for (int c = 0; c < N; c++) m_state_packed |= int'(m_state[c]) << c;
    chk("model_btn_state", int'(state), m_state_packed);
    chk("model_evt_valid", int'(evt_bus.evt_valid), int'(m_valid));
    chk("model_overflow", int'(ovf), int'(m_ovf));
    if (m_valid && evt_bus.evt_valid) begin
      chk("model_evt_id", int'(evt_bus.evt_id), m_id);
      chk("model_evt_press", int'(evt_bus.evt_press), int'(m_press));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ready_pulse();
    evt_bus.evt_ready = 1'b1;
    tick();
    evt_bus.evt_ready = 1'b0;
  endtask

  int hold[N];

  initial begin
    rst = 1'b1;
    raw = 4'hF;
    evt_bus.evt_ready = 1'b0;

    // 1: reset, then idle with nothing pressed
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_valid", int'(evt_bus.evt_valid), 0);
    chk("reset_id", int'(evt_bus.evt_id), 0);
    chk("reset_press", int'(evt_bus.evt_press), 0);
    chk("reset_ovf", int'(ovf), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", int'(evt_bus.evt_valid), 0);
    end

    // 2: single press then release, consumer always ready
    evt_bus.evt_ready = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      raw[2] = (ph == 1);
      repeat (5) tick();
      chk("lat_state_before", int'(state[2]), ph);
      tick();
      chk("lat_state_after", int'(state[2]), 1 - ph);
      chk("lat_valid_early", int'(evt_bus.evt_valid), 0);
      tick();
      chk("lat_valid", int'(evt_bus.evt_valid), 1);
      chk("lat_id", int'(evt_bus.evt_id), 2);
      chk("lat_press", int'(evt_bus.evt_press), 1 - ph);
      tick();
      chk("lat_valid_drop", int'(evt_bus.evt_valid), 0);
    end

    // 3: glitch shorter than the stability window
    raw[0] = 1'b0;
    repeat (3) tick();
    raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_state", int'(state[0]), 0);
      chk("glitch_valid", int'(evt_bus.evt_valid), 0);
    end

    // 4: two channels on the same edge, stalled consumer
    evt_bus.evt_ready = 1'b0;
    raw[1] = 1'b0; raw[3] = 1'b0;
    repeat (7) tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", int'(evt_bus.evt_valid), 1);
      chk("stall_id", int'(evt_bus.evt_id), 1);
      tick();
    end
    ready_pulse();
    chk("second_valid", int'(evt_bus.evt_valid), 1);
    chk("second_id", int'(evt_bus.evt_id), 3);
    chk("second_press", int'(evt_bus.evt_press), 1);
    ready_pulse();
    chk("drained_valid", int'(evt_bus.evt_valid), 0);
    raw = 4'hF;
    evt_bus.evt_ready = 1'b1;
    repeat (14) tick();
    chk("release_drained", int'(evt_bus.evt_valid), 0);

    // 5: overflow by merging events on a stalled stream
    evt_bus.evt_ready = 1'b0;
    raw[0] = 1'b0; repeat (8) tick();
    raw[0] = 1'b1; repeat (8) tick();
    raw[0] = 1'b0; repeat (8) tick();
    chk("ovf_before", int'(ovf), 0);
    raw[0] = 1'b1; repeat (8) tick();
    chk("ovf_after", int'(ovf), 1);
    chk("drain0_valid", int'(evt_bus.evt_valid), 1);
    chk("drain0_id", int'(evt_bus.evt_id), 0);
    chk("drain0_press", int'(evt_bus.evt_press), 1);
    ready_pulse();
    chk("drain1_id", int'(evt_bus.evt_id), 0);
    chk("drain1_press", int'(evt_bus.evt_press), 1);
    ready_pulse();
    chk("drain2_valid", int'(evt_bus.evt_valid), 1);
    chk("drain2_press", int'(evt_bus.evt_press), 0);
    ready_pulse();
    chk("drain3_valid", int'(evt_bus.evt_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);

    // 6: reset with an event in flight and the button still held
    rst = 1'b1; tick(); rst = 1'b0; tick();
    raw[1] = 1'b0;
    repeat (7) tick();
    chk("pre_reset_valid", int'(evt_bus.evt_valid), 1);
    chk("pre_reset_id", int'(evt_bus.evt_id), 1);
    rst = 1'b1; tick();
    chk("mid_reset_valid", int'(evt_bus.evt_valid), 0);
    chk("mid_reset_state", int'(state), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("redetect_before", int'(state[1]), 0);
    tick();
    chk("redetect_state", int'(state[1]), 1);
    tick();
    chk("redetect_valid", int'(evt_bus.evt_valid), 1);
    chk("redetect_id", int'(evt_bus.evt_id), 1);
    chk("redetect_press", int'(evt_bus.evt_press), 1);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 12);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          raw[c] = ~raw[c];
          hold[c] = $urandom_range(1, 12);
        end
      end
      evt_bus.evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    evt_bus.evt_ready = 1'b1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
